// File: rtl/operand_pkg.sv
// Shared constants and types for the key-to-operand conditioning path.
// Key polarity, default debounce length and per-channel event bundle.
package operand_pkg;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  localparam int CLK_HZ = 50000000;

  // 10 ms of stability at CLK_HZ
  localparam int DEB_CYCLES_DEFAULT = CLK_HZ / 100;

  // acc: stable level flips on this edge
  // lvl: level being accepted
  typedef struct packed {
    logic acc;
    logic lvl;
  } ch_evt_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, stability counter, accepted level.
// Exports the accept event so the parent can register on the same edge.
module key_debounce_ch
  import operand_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    key_raw,
  output logic    press,
  output ch_evt_t evt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             diff;
  logic             acc;

  assign diff = (sync2 != stable);
  assign acc  = diff && (cnt == CNT_MAX);

  assign evt.acc = acc;
  assign evt.lvl = sync2;

  // bring the asynchronous key level into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= KEY_RELEASED;
      sync2 <= KEY_RELEASED;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // count consecutive disagreement; any agreement discards progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= KEY_RELEASED;
      cnt    <= '0;
    end else if (!diff) begin
      cnt    <= '0;
    end else if (acc) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + CNT_ONE;
    end
  end

  // single-cycle pulse when a press is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press <= 1'b0;
    end else begin
      press <= acc && (sync2 == KEY_PRESSED);
    end
  end

endmodule

// File: rtl/operand_debouncer.sv
// Debounced push-buttons to adder operand bits, press pulses, update strobe.
// OPERAND_TOGGLE_EN: operand toggles per press; else it follows the key.
module operand_debouncer
  import operand_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] key_raw,
  output logic [N_CH-1:0] operand,
  output logic [N_CH-1:0] press,
  output logic            upd
);

  ch_evt_t         evt [N_CH];
  logic [N_CH-1:0] operand_nxt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_raw (key_raw[i]),
      .press   (press[i]),
      .evt     (evt[i])
    );
  end

  // next operand value from each channel's accept event
  always_comb begin
    operand_nxt = operand;
    for (int i = 0; i < N_CH; i++) begin
`ifdef OPERAND_TOGGLE_EN
      if (evt[i].acc && (evt[i].lvl == KEY_PRESSED)) begin
        operand_nxt[i] = ~operand[i];
      end
`else
      if (evt[i].acc) begin
        operand_nxt[i] = (evt[i].lvl == KEY_PRESSED);
      end
`endif
    end
  end

  // operand register plus one shared strobe for any change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand <= '0;
      upd     <= 1'b0;
    end else begin
      operand <= operand_nxt;
      upd     <= |(operand_nxt ^ operand);
    end
  end

endmodule

// File: tb/tb_operand_debouncer.sv
// Bench for operand_debouncer: window-based reference model feeding a
// scoreboard queue, checked by an independent monitor after each edge.
module tb_operand_debouncer;

  localparam int N   = 2;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] key_raw;
  logic [N-1:0] operand;
  logic [N-1:0] press;
  logic         upd;

  always #5 clk = ~clk;

  operand_debouncer #(
    .N_CH       (N),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (key_raw),
    .operand (operand),
    .press   (press),
    .upd     (upd)
  );

  typedef struct {
    logic [N-1:0] op;
    logic [N-1:0] pr;
    logic         up;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  bit           hist [N][$];
  logic [N-1:0] m_stable = '1;
  logic [N-1:0] m_op = '0;

  int edge_n = 0;
  int first_press = -1;

  task automatic check(input string name, input logic [N-1:0] got,
                       input logic [N-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  // Reference: a level is accepted when the last DEB synchronised samples
  // (raw delayed by two edges, released before any post-reset sample) all
  // disagree with the currently accepted level.
  task automatic model_edge(input logic r, input logic [N-1:0] raw);
    exp_t         e;
    logic [N-1:0] old_op;
    bit           acc;
    bit           s;
    int           k;
    e.op = '0;
    e.pr = '0;
    e.up = 1'b0;
    if (!r) begin
      for (int i = 0; i < N; i++) hist[i].delete();
      m_stable = '1;
      m_op = '0;
    end else begin
      old_op = m_op;
      for (int i = 0; i < N; i++) begin
        hist[i].push_back(raw[i]);
        acc = 1'b1;
        for (int j = 0; j < DEB; j++) begin
          k = hist[i].size() - 3 - j;
          s = (k >= 0) ? hist[i][k] : 1'b1;
          if (s == m_stable[i]) acc = 1'b0;
        end
        if (acc) begin
          m_stable[i] = ~m_stable[i];
          if (!m_stable[i]) e.pr[i] = 1'b1;
`ifdef OPERAND_TOGGLE_EN
          if (!m_stable[i]) m_op[i] = ~m_op[i];
`else
          m_op[i] = ~m_stable[i];
`endif
        end
      end
      e.op = m_op;
      e.up = (m_op != old_op);
    end
    q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [N-1:0] raw);
    @(negedge clk);
    rst_n = r;
    key_raw = raw;
    model_edge(r, raw);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // monitor: one expectation per clock edge, popped just after the edge
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) edge_n = 0;
      else edge_n++;
      if (rst_n && press[0] && first_press < 0) first_press = edge_n;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("operand", operand, e.op);
        check("press", press, e.pr);
        check("upd", {{(N-1){1'b0}}, upd}, {{(N-1){1'b0}}, e.up});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int           len [N];
    logic [N-1:0] lvl;
    rst_n = 1'b0;
    key_raw = '1;
    #1;
    check("reset_operand", operand, '0);
    check("reset_press", press, '0);

    repeat (3) step(1'b0, '1);
    repeat (20) step(1'b1, '1);

    step(1'b0, '1);
    first_press = -1;
    repeat (10) step(1'b1, 2'b10);
    settle();
    check("press_latency", N'(first_press), N'(DEB + 2));
    repeat (10) step(1'b1, '1);

    repeat (3) step(1'b1, 2'b01);
    step(1'b1, 2'b11);
    repeat (8) step(1'b1, 2'b01);
    repeat (8) step(1'b1, 2'b11);

    repeat (8) step(1'b1, 2'b00);
    repeat (8) step(1'b1, 2'b11);
    repeat (8) step(1'b1, 2'b00);
    repeat (8) step(1'b1, 2'b11);

    step(1'b0, '1);
    repeat (4) step(1'b1, 2'b10);
    repeat (2) step(1'b0, 2'b10);
    settle();
    check("reset_mid_operand", operand, '0);
    first_press = -1;
    repeat (10) step(1'b1, 2'b10);
    settle();
    check("press_after_reset", N'(first_press), N'(DEB + 2));
    repeat (10) step(1'b1, '1);

    lvl = '1;
    for (int i = 0; i < N; i++) len[i] = 1;
    for (int c = 0; c < 700; c++) begin
      for (int i = 0; i < N; i++) begin
        len[i]--;
        if (len[i] <= 0) begin
          lvl[i] = ~lvl[i];
          len[i] = $urandom_range(1, 2 * DEB + 2);
        end
      end
      step(($urandom_range(0, 199) != 0), lvl);
    end
    repeat (12) step(1'b1, '1);
    settle();
    check("queue_drained", N'(q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
